// File: rtl/wnd_bitmap_wr.sv
// Write side of a sliding-window bitmap: set/clear by absolute index and window
// advance, with registered bitmap/base and per-set hit status.
module wnd_bitmap_wr #(
  parameter int WND_SIZE  = 128,
  parameter int IND_WIDTH = 32,
  parameter int ADV_WIDTH = $clog2(WND_SIZE) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 init_val_in,
  input  logic [IND_WIDTH-1:0] init_base_in,
  input  logic                 set_val_in,
  input  logic [IND_WIDTH-1:0] set_ind_in,
  input  logic                 clr_val_in,
  input  logic [IND_WIDTH-1:0] clr_ind_in,
  input  logic                 adv_val_in,
  input  logic [ADV_WIDTH-1:0] adv_cnt_in,
  output logic [WND_SIZE-1:0]  bitmap_out,
  output logic [IND_WIDTH-1:0] base_out,
  output logic                 set_new_out,
  output logic                 set_dup_out,
  output logic                 set_oow_out,
  output logic [15:0]          drop_cnt_out
);

  localparam int LOG_W = $clog2(WND_SIZE);

  logic [WND_SIZE-1:0]  bitmap_reg, bitmap_next;
  logic [IND_WIDTH-1:0] base_reg, base_next;
  logic                 set_new_reg, set_new_next;
  logic                 set_dup_reg, set_dup_next;
  logic                 set_oow_reg, set_oow_next;
  logic [15:0]          drop_cnt_reg, drop_cnt_next;

  logic [IND_WIDTH-1:0] set_off, clr_off;
  logic                 set_in_wnd, clr_in_wnd;
  logic [WND_SIZE-1:0]  set_mask, clr_mask, pre_shift, shifted;
  logic [LOG_W:0]       adv_eff;
  logic [1:0]           drop_inc;
  logic [16:0]          drop_sum;

  // Offsets wrap modulo 2^IND_WIDTH, so indices behind the base look huge.
  assign set_off    = set_ind_in - base_reg;
  assign clr_off    = clr_ind_in - base_reg;
  assign set_in_wnd = (set_off[IND_WIDTH-1:LOG_W] == '0);
  assign clr_in_wnd = (clr_off[IND_WIDTH-1:LOG_W] == '0);

  assign set_mask = (set_val_in && set_in_wnd) ?
                    ({{(WND_SIZE-1){1'b0}}, 1'b1} << set_off[LOG_W-1:0]) : '0;
  assign clr_mask = (clr_val_in && clr_in_wnd) ?
                    ({{(WND_SIZE-1){1'b0}}, 1'b1} << clr_off[LOG_W-1:0]) : '0;

  assign pre_shift = (bitmap_reg | set_mask) & ~clr_mask;

  always_comb begin
    adv_eff = '0;
    if (adv_val_in) begin
      if (adv_cnt_in > ADV_WIDTH'(WND_SIZE))
        adv_eff = (LOG_W+1)'(WND_SIZE);
      else
        adv_eff = adv_cnt_in[LOG_W:0];
    end
  end

  // Log-depth barrel shifter; the top bit of adv_eff means a full-window slide.
  logic [WND_SIZE-1:0] stage [0:LOG_W];
  assign stage[0] = pre_shift;
  generate
    for (genvar gi = 0; gi < LOG_W; gi++) begin : g_shift
      assign stage[gi+1] = adv_eff[gi] ? (stage[gi] >> (2**gi)) : stage[gi];
    end
  endgenerate
  assign shifted = adv_eff[LOG_W] ? '0 : stage[LOG_W];

  assign drop_inc = {1'b0, set_val_in && !set_in_wnd} + {1'b0, clr_val_in && !clr_in_wnd};
  assign drop_sum = {1'b0, drop_cnt_reg} + {15'd0, drop_inc};

  always_comb begin
    bitmap_next   = shifted;
    base_next     = base_reg + IND_WIDTH'(adv_eff);
    set_new_next  = set_val_in && set_in_wnd && !bitmap_reg[set_off[LOG_W-1:0]];
    set_dup_next  = set_val_in && set_in_wnd &&  bitmap_reg[set_off[LOG_W-1:0]];
    set_oow_next  = set_val_in && !set_in_wnd;
    drop_cnt_next = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    if (init_val_in) begin
      bitmap_next   = '0;
      base_next     = init_base_in;
      set_new_next  = 1'b0;
      set_dup_next  = 1'b0;
      set_oow_next  = 1'b0;
      drop_cnt_next = drop_cnt_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bitmap_reg   <= '0;
      base_reg     <= '0;
      set_new_reg  <= 1'b0;
      set_dup_reg  <= 1'b0;
      set_oow_reg  <= 1'b0;
      drop_cnt_reg <= '0;
    end else begin
      bitmap_reg   <= bitmap_next;
      base_reg     <= base_next;
      set_new_reg  <= set_new_next;
      set_dup_reg  <= set_dup_next;
      set_oow_reg  <= set_oow_next;
      drop_cnt_reg <= drop_cnt_next;
    end
  end

  assign bitmap_out   = bitmap_reg;
  assign base_out     = base_reg;
  assign set_new_out  = set_new_reg;
  assign set_dup_out  = set_dup_reg;
  assign set_oow_out  = set_oow_reg;
  assign drop_cnt_out = drop_cnt_reg;

endmodule
